io_port_responder: RTL

//  Memory-mapped byte I/O responder on the proc address/data bus. It is the target end of the
//  bus the core drives (address, wr_data, wr_enable, rd_data) and sits beside memory_block.
//  CPU writes to TXDATA queue bytes in a TX FIFO, which drains on a valid/ready output stream.

---
 rtl/io_port_responder.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/io_port_responder.sv
// io_port_responder: memory-mapped byte I/O target with a TX FIFO and a one-entry RX holding register.
// Define IO_PORT_IRQ_EN to add the irq output and make STATUS.ie writable.
module io_port_responder #(
  parameter logic [15:0] BASE_ADDR  = 16'hD000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic [7:0]  wr_data,
  input  logic        wr_enable,
  output logic [7:0]  rd_data,
  output logic        hit,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
`ifdef IO_PORT_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] OFF_TXDATA  = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_RXDATA  = 2'd2;
  localparam logic [1:0] OFF_TXCOUNT = 2'd3;

  logic          sel;
  logic [1:0]    offset;
  logic          bus_wr;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;

  logic          push_req;
  logic          push;
  logic          pop;
  logic          drop;

  logic          ovf;
  logic          ovf_clr;
  logic          ie;

  logic          rx_full;
  logic [7:0]    rx_buf;
  logic          capture;
  logic          ack;

  logic [7:0]    status;
  logic [7:0]    rd_next;

  assign sel    = (address[15:2] == BASE_ADDR[15:2]);
  assign offset = address[1:0];
  assign bus_wr = wr_enable & sel;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  // A push into a full FIFO is still accepted when the head leaves on the same edge.
  assign pop      = tx_valid & tx_ready;
  assign push_req = bus_wr & (offset == OFF_TXDATA);
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;
  assign ovf_clr  = bus_wr & (offset == OFF_STATUS) & wr_data[7];

  assign capture = rx_valid & rx_ready;
  assign ack     = bus_wr & (offset == OFF_RXDATA);

  assign tx_valid = ~empty;
  assign tx_data  = mem[rd_ptr];
  assign rx_ready = ~rx_full;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Overflow is sticky; a drop on the same edge as a clear keeps it set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_full <= 1'b0;
      rx_buf  <= 8'h00;
    end else if (capture) begin
      rx_full <= 1'b1;
      rx_buf  <= rx_data;
    end else if (ack) begin
      rx_full <= 1'b0;
    end
  end

`ifdef IO_PORT_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ie <= 1'b0;
    end else if (bus_wr && (offset == OFF_STATUS)) begin
      ie <= wr_data[3];
    end
  end

  // Level interrupt, one clock behind the state that causes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= ie & (rx_full | ovf);
    end
  end
`else
  assign ie = 1'b0;
`endif

  assign status = {ovf, 2'b00, rx_full, ie, full, empty, 1'b0};

  always_comb begin
    rd_next = 8'h00;
    if (sel) begin
      case (offset)
        OFF_TXDATA:  rd_next = 8'h00;
        OFF_STATUS:  rd_next = status;
        OFF_RXDATA:  rd_next = rx_buf;
        OFF_TXCOUNT: rd_next = 8'(count);
        default:     rd_next = 8'h00;
      endcase
    end
  end

  // Reads are sampled every edge and reflect the state before that edge's updates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data <= 8'h00;
      hit     <= 1'b0;
    end else begin
      rd_data <= rd_next;
      hit     <= sel;
    end
  end

endmodule
